stack_sequencer: RTL and testbench
==================================

// Module: stack_sequencer
// PURPOSE
//  Multi-cycle controller for the data stack. Executes the stackOP codes emitted by the
//  instruction decoder against a 2-register cache (TOS/NOS) backed by a single-port RAM.
//  Sits between the decoder/ALU and stack storage; stalls the core via ready while refilling.
// PARAMETERS
//  WIDTH  16  data word width
//  DEPTH  64  total stack capacity incl. TOS/NOS; RAM holds DEPTH-2 words (DEPTH>=4)
// PORTS
//  clk       in   1               rising-edge clock
//  reset     in   1               asynchronous, active-high
//  op_valid  in   1               op request; accepted when op_valid & ready
//  op        in   3               0 NONE,1 PUSH,2 POPANDREPLACE,3 POP,4 POP2,5 SWAP; 6-7 illegal
//  wdata     in   WIDTH           PUSH value / POPANDREPLACE ALU result
//  err_clr   in   1               clears all sticky error flags
//  ready     out  1               1 in IDLE; 0 while refilling
//  op_done   out  1               1-cycle pulse; new TOS/NOS/depth visible in the same cycle
//  tos       out  WIDTH           top of stack (0 when depth==0)
//  nos       out  WIDTH           next on stack (0 when depth<2)
//  depth     out  clog2(DEPTH+1)  current entry count
//  err_ovf   out  1               sticky: PUSH at depth==DEPTH
//  err_unf   out  1               sticky: operand underflow
//  err_ill   out  1               sticky: op 6 or 7
// BEHAVIOUR
//  - Reset (any time, incl. mid-op): state IDLE, sp=0, depth=0, tos=nos=0, op_done=0,
//    all err=0, ready=1 after reset deasserts. RAM contents not cleared.
//  - States: IDLE, FILL_NOS, FILL_TOS, FILL_NOS2. ready = (state==IDLE). op_valid ignored
//    while busy; requester holds op/wdata until accepted.
//  - sp = RAM word count = max(depth-2,0). RAM: sync write, sync read, 1-cycle latency.
//  - PUSH: RAM[sp]<=nos if depth>=2; nos<=tos; tos<=wdata; depth++. done next cycle.
//  - SWAP: tos<->nos. done next cycle. Needs depth>=2.
//  - POP: tos<=nos; depth--. If sp>0: read RAM[sp-1], FILL_NOS latches nos; done 2 cycles
//    after accept; else nos<=0, done next cycle. Needs depth>=1.
//  - POPANDREPLACE: tos<=wdata; depth--; nos refilled as POP. Needs depth>=2.
//  - POP2: depth-=2. sp>=2: FILL_TOS then FILL_NOS2 (two reads), done 3 cycles after accept.
//    sp==1: one read to tos, nos<=0, done 2 cycles after accept. sp==0: tos=nos=0, done next.
//    Needs depth>=2.
//  - NONE: no state change, done next cycle.
//  - Error cases (ovf, unf, ill): no stack/sp/depth change, flag set, done still pulses next cycle.
//  - err_clr and a new error in the same cycle: set wins.
//  - depth/sp never wrap; overflow/underflow guards are the only boundary actions.
//  - op_done registered; exactly one pulse per accepted op; back-to-back ops legal when
//    ready (accept possible in the same cycle op_done pulses).
// STRUCTURE
//  - stack_defs.vh: op codes (shared with the decoder), state encodings.
//  - Sub-module stack_ram (single-port, WIDTH x DEPTH-2, sync read); all sequencing,
//    cache registers and error logic in stack_sequencer.
// TESTING
//  1. reset; PUSH 5,6,7 -> tos=7, nos=6, depth=3, RAM[0]=5; each op_done 1 cycle after accept.
//  2. from (1) POP -> ready low 1 cycle, op_done 2 cycles after accept, tos=6, nos=5, depth=2.
//  3. PUSH 1..6; POP2 -> done 3 cycles after accept, tos=4, nos=3, depth=4.
//  4. depth=2 (tos=6,nos=5), POPANDREPLACE wdata=11 -> tos=11, nos=0, depth=1, done next cycle.
//  5. empty POP -> err_unf=1, depth=0; fill to 64, PUSH -> err_ovf=1, depth=64; op=7 -> err_ill=1;
//     err_clr -> all 0.
//  6. assert reset during FILL_TOS of POP2 -> immediately IDLE, depth=0, tos=nos=0, op_done=0.

Source files
------------

// File: rtl/stack_sequencer_pkg.sv
// Shared definitions for the data-stack sequencer: stack op codes (common with the decoder)
// and the refill state encoding.
package stack_sequencer_pkg;

    typedef enum logic [2:0] {
        OpNone   = 3'd0,
        OpPush   = 3'd1,
        OpPopRep = 3'd2,
        OpPop    = 3'd3,
        OpPop2   = 3'd4,
        OpSwap   = 3'd5
    } op_e;

    typedef enum logic [1:0] {
        StIdle,
        StFillNos,
        StFillTos,
        StFillNos2
    } state_e;

endpackage

// File: rtl/stack_sequencer_ram.sv
// Single-port stack spill RAM: synchronous write, synchronous read with one cycle latency.
module stack_sequencer_ram #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned WORDS = 62
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(WORDS)-1:0] addr,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/stack_sequencer.sv
// Data-stack controller: TOS/NOS register cache in front of a spill RAM, with multi-cycle
// refill after pops and sticky error reporting.
module stack_sequencer
    import stack_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       op_valid,
    input  logic [2:0]                 op,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       err_clr,
    output logic                       ready,
    output logic                       op_done,
    output logic [WIDTH-1:0]           tos,
    output logic [WIDTH-1:0]           nos,
    output logic [$clog2(DEPTH+1)-1:0] depth,
    output logic                       err_ovf,
    output logic                       err_unf,
    output logic                       err_ill
);

    localparam int unsigned DW = $clog2(DEPTH + 1);
    localparam int unsigned RW = DEPTH - 2;
    localparam int unsigned AW = $clog2(RW);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] tos_q, tos_d, nos_q, nos_d;
    logic [DW-1:0]    depth_q, depth_d;
    logic             done_q, done_d;
    logic             ovf_q, ovf_d, unf_q, unf_d, ill_q, ill_d;

    logic [DW-1:0]    sp;
    logic             ram_we;
    logic [AW-1:0]    ram_addr;
    logic [WIDTH-1:0] ram_rdata;

    // Words spilled to RAM; the top two entries always live in tos/nos.
    assign sp = (depth_q > DW'(2)) ? depth_q - DW'(2) : '0;

    stack_sequencer_ram #(
        .WIDTH(WIDTH),
        .WORDS(RW)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .addr (ram_addr),
        .wdata(nos_q),
        .rdata(ram_rdata)
    );

    always_comb begin
        state_d  = state_q;
        tos_d    = tos_q;
        nos_d    = nos_q;
        depth_d  = depth_q;
        done_d   = 1'b0;
        ovf_d    = ovf_q & ~err_clr;
        unf_d    = unf_q & ~err_clr;
        ill_d    = ill_q & ~err_clr;
        ram_we   = 1'b0;
        ram_addr = AW'(sp - DW'(1));

        unique case (state_q)
            StIdle: begin
                if (op_valid) begin
                    done_d = 1'b1;
                    case (op)
                        OpNone: ;
                        OpPush: begin
                            if (depth_q == DW'(DEPTH)) begin
                                ovf_d = 1'b1;
                            end else begin
                                ram_we   = (depth_q >= DW'(2));
                                ram_addr = AW'(sp);
                                nos_d    = tos_q;
                                tos_d    = wdata;
                                depth_d  = depth_q + DW'(1);
                            end
                        end
                        OpSwap: begin
                            if (depth_q < DW'(2)) begin
                                unf_d = 1'b1;
                            end else begin
                                tos_d = nos_q;
                                nos_d = tos_q;
                            end
                        end
                        OpPop, OpPopRep: begin
                            if (depth_q < ((op == OpPop) ? DW'(1) : DW'(2))) begin
                                unf_d = 1'b1;
                            end else begin
                                tos_d   = (op == OpPop) ? nos_q : wdata;
                                depth_d = depth_q - DW'(1);
                                if (sp != '0) begin
                                    state_d = StFillNos;
                                    done_d  = 1'b0;
                                end else begin
                                    nos_d = '0;
                                end
                            end
                        end
                        OpPop2: begin
                            if (depth_q < DW'(2)) begin
                                unf_d = 1'b1;
                            end else begin
                                depth_d = depth_q - DW'(2);
                                if (sp != '0) begin
                                    state_d = StFillTos;
                                    done_d  = 1'b0;
                                end else begin
                                    tos_d = '0;
                                    nos_d = '0;
                                end
                            end
                        end
                        default: ill_d = 1'b1;
                    endcase
                end
            end
            StFillTos: begin
                tos_d = ram_rdata;
                // depth is already post-pop; a second read is needed only if nos has a source
                if (depth_q >= DW'(2)) begin
                    ram_addr = AW'(sp);
                    state_d  = StFillNos2;
                end else begin
                    nos_d   = '0;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            StFillNos, StFillNos2: begin
                nos_d   = ram_rdata;
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            tos_q   <= '0;
            nos_q   <= '0;
            depth_q <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tos_q   <= tos_d;
            nos_q   <= nos_d;
            depth_q <= depth_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            ill_q   <= ill_d;
        end
    end

    assign ready   = (state_q == StIdle);
    assign op_done = done_q;
    assign tos     = tos_q;
    assign nos     = nos_q;
    assign depth   = depth_q;
    assign err_ovf = ovf_q;
    assign err_unf = unf_q;
    assign err_ill = ill_q;

endmodule

// File: tb/tb_stack_sequencer.sv
// Directed self-checking bench for stack_sequencer: push/pop/refill latencies, boundary errors,
// sticky flag clearing and asynchronous reset in the middle of a refill.
module tb_stack_sequencer;
    import stack_sequencer_pkg::*;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned DEPTH = 64;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             op_valid = 1'b0;
    logic [2:0]       op = 3'd0;
    logic [WIDTH-1:0] wdata = '0;
    logic             err_clr = 1'b0;
    logic             ready, op_done, err_ovf, err_unf, err_ill;
    logic [WIDTH-1:0] tos, nos;
    logic [6:0]       depth;

    int checks = 0;
    int errors = 0;

    stack_sequencer #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .op_valid(op_valid),
        .op      (op),
        .wdata   (wdata),
        .err_clr (err_clr),
        .ready   (ready),
        .op_done (op_done),
        .tos     (tos),
        .nos     (nos),
        .depth   (depth),
        .err_ovf (err_ovf),
        .err_unf (err_unf),
        .err_ill (err_ill)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Issue one op at a falling edge and measure cycles from accept to op_done.
    task automatic run_op(input logic [2:0] o, input logic [WIDTH-1:0] d, input int lat,
                          input string tag);
        int n;
        op_valid = 1'b1;
        op       = o;
        wdata    = d;
        @(posedge clk);
        @(negedge clk);
        op_valid = 1'b0;
        chk({tag, ".ready"}, 32'(ready), 32'(lat == 1));
        n = 1;
        while (!op_done && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk({tag, ".latency"}, 32'(n), 32'(lat));
    endtask

    task automatic chk_stack(input string tag, input int t, input int s, input int dp);
        chk({tag, ".tos"}, 32'(tos), 32'(t));
        chk({tag, ".nos"}, 32'(nos), 32'(s));
        chk({tag, ".depth"}, 32'(depth), 32'(dp));
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst.ready_in_reset", 32'(ready), 32'd1);
        reset = 1'b0;
        @(negedge clk);
        chk_stack("rst", 0, 0, 0);
        chk("rst.op_done", 32'(op_done), 32'd0);
        chk("rst.errs", {29'd0, err_ovf, err_unf, err_ill}, 32'd0);

        // Three pushes, then a pop that refills nos from RAM[0]
        run_op(OpPush, 16'd5, 1, "push5");
        run_op(OpPush, 16'd6, 1, "push6");
        run_op(OpPush, 16'd7, 1, "push7");
        chk_stack("push567", 7, 6, 3);
        run_op(OpPop, 16'd0, 2, "pop_refill");
        chk_stack("pop_refill", 6, 5, 2);

        // Pop-and-replace with nothing spilled
        run_op(OpPopRep, 16'd11, 1, "poprep");
        chk_stack("poprep", 11, 0, 1);
        run_op(OpPush, 16'd3, 1, "push3");
        run_op(OpSwap, 16'd0, 1, "swap");
        chk_stack("swap", 11, 3, 2);
        run_op(OpPop, 16'd0, 1, "pop_d2");
        chk_stack("pop_d2", 3, 0, 1);
        run_op(OpPop, 16'd0, 1, "pop_d1");
        chk_stack("pop_d1", 0, 0, 0);
        run_op(OpPop, 16'd0, 1, "pop_empty");
        chk("pop_empty.err_unf", 32'(err_unf), 32'd1);
        chk_stack("pop_empty", 0, 0, 0);
        run_op(OpNone, 16'd0, 1, "none");
        chk("none.err_unf_sticky", 32'(err_unf), 32'd1);

        // POP2 with two, then one, spilled words
        pulse_reset();
        chk("rst2.err_unf", 32'(err_unf), 32'd0);
        for (int i = 1; i <= 6; i++) run_op(OpPush, 16'(i), 1, "push1to6");
        chk_stack("push1to6", 6, 5, 6);
        run_op(OpPop2, 16'd0, 3, "pop2_a");
        chk_stack("pop2_a", 4, 3, 4);
        run_op(OpPop2, 16'd0, 3, "pop2_b");
        chk_stack("pop2_b", 2, 1, 2);
        run_op(OpPush, 16'd9, 1, "push9");
        run_op(OpPop2, 16'd0, 2, "pop2_sp1");
        chk_stack("pop2_sp1", 1, 0, 1);
        run_op(OpSwap, 16'd0, 1, "swap_d1");
        chk("swap_d1.err_unf", 32'(err_unf), 32'd1);
        chk_stack("swap_d1", 1, 0, 1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("clr.err_unf", 32'(err_unf), 32'd0);

        // Fill to capacity, overflow, illegal op, clear, set-beats-clear
        pulse_reset();
        for (int i = 1; i <= 64; i++) run_op(OpPush, 16'(i), 1, "fill");
        chk_stack("full", 64, 63, 64);
        run_op(OpPush, 16'd99, 1, "push_full");
        chk("push_full.err_ovf", 32'(err_ovf), 32'd1);
        chk_stack("push_full", 64, 63, 64);
        run_op(3'd7, 16'd0, 1, "op7");
        chk("op7.err_ill", 32'(err_ill), 32'd1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("clr_all.errs", {29'd0, err_ovf, err_unf, err_ill}, 32'd0);
        run_op(OpPush, 16'd99, 1, "push_full2");
        err_clr  = 1'b1;
        op_valid = 1'b1;
        op       = 3'd6;
        @(negedge clk);
        err_clr  = 1'b0;
        op_valid = 1'b0;
        chk("set_wins.errs", {29'd0, err_ovf, err_unf, err_ill}, 32'd1);
        chk("set_wins.op_done", 32'(op_done), 32'd1);
        @(negedge clk);
        run_op(OpPop, 16'd0, 2, "pop_full");
        chk_stack("pop_full", 63, 62, 63);

        // Asynchronous reset while in the first refill read of POP2
        op_valid = 1'b1;
        op       = OpPop2;
        @(posedge clk);
        @(negedge clk);
        op_valid = 1'b0;
        chk("mid.ready", 32'(ready), 32'd0);
        #1 reset = 1'b1;
        #1;
        chk_stack("mid_rst", 0, 0, 0);
        chk("mid_rst.op_done", 32'(op_done), 32'd0);
        chk("mid_rst.ready", 32'(ready), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst.op_done", 32'(op_done), 32'd0);
        run_op(OpPush, 16'd8, 1, "post_rst_push");
        chk_stack("post_rst_push", 8, 0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
